// File: rtl/iq_dac_spi_tx.sv
// Serialises a captured I/Q pair to a dual-channel SPI DAC: channel A frame (I), then channel B (Q).
// Optional macro DAC_LDAC_EN adds a post-frame LDAC pulse so both DAC outputs update together.
module iq_dac_spi_tx #(
   parameter int         BIT_WIDTH = 10,
   parameter int         CLK_DIV   = 2,
   parameter int         CS_GAP    = 2,
   parameter logic [3:0] CMD_A     = 4'b0011,
   parameter logic [3:0] CMD_B     = 4'b1011
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic                 en_in,
   input  logic                 sample_stb,
   input  logic [BIT_WIDTH-1:0] I_in,
   input  logic [BIT_WIDTH-1:0] Q_in,
   output logic                 busy,
   output logic                 done,
   output logic                 overrun,
   output logic                 sclk,
   output logic                 cs_n,
   output logic                 mosi,
   output logic                 ldac_n
);

   localparam int PAD   = 12 - BIT_WIDTH;
   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int GAP_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP - 1);

`ifdef DAC_LDAC_EN
   localparam logic LDAC_IDLE = 1'b1;
`else
   localparam logic LDAC_IDLE = 1'b0;
`endif

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SHIFT_A = 3'd1,
      ST_GAP_A   = 3'd2,
      ST_SHIFT_B = 3'd3,
      ST_GAP_B   = 3'd4
`ifdef DAC_LDAC_EN
      , ST_LDAC  = 3'd5
`endif
   } state_t;

   state_t           state_reg, state_next;
   logic [DIV_W-1:0] div_cnt_reg, div_cnt_next;
   logic             phase_reg, phase_next;
   logic [3:0]       bit_cnt_reg, bit_cnt_next;
   logic [GAP_W-1:0] gap_cnt_reg, gap_cnt_next;
   logic [15:0]      shift_reg, shift_next;
   logic [15:0]      q_frame_reg, q_frame_next;

   logic busy_reg, busy_next;
   logic done_reg, done_next;
   logic sclk_reg, sclk_next;
   logic cs_n_reg, cs_n_next;
   logic mosi_reg, mosi_next;
   logic ldac_n_reg, ldac_n_next;

   logic [11:0] i_data12;
   logic [11:0] q_data12;

   // Left-justify the samples into the 12-bit DAC data field, zero-filling the LSBs.
   for (genvar gi = 0; gi < 12; gi++) begin : g_pad
      if (gi >= PAD) begin : g_data
         assign i_data12[gi] = I_in[gi-PAD];
         assign q_data12[gi] = Q_in[gi-PAD];
      end else begin : g_zero
         assign i_data12[gi] = 1'b0;
         assign q_data12[gi] = 1'b0;
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_reg   <= ST_IDLE;
         div_cnt_reg <= '0;
         phase_reg   <= 1'b0;
         bit_cnt_reg <= '0;
         gap_cnt_reg <= '0;
         shift_reg   <= '0;
         q_frame_reg <= '0;
         busy_reg    <= 1'b0;
         done_reg    <= 1'b0;
         sclk_reg    <= 1'b0;
         cs_n_reg    <= 1'b1;
         mosi_reg    <= 1'b0;
         ldac_n_reg  <= LDAC_IDLE;
      end else begin
         state_reg   <= state_next;
         div_cnt_reg <= div_cnt_next;
         phase_reg   <= phase_next;
         bit_cnt_reg <= bit_cnt_next;
         gap_cnt_reg <= gap_cnt_next;
         shift_reg   <= shift_next;
         q_frame_reg <= q_frame_next;
         busy_reg    <= busy_next;
         done_reg    <= done_next;
         sclk_reg    <= sclk_next;
         cs_n_reg    <= cs_n_next;
         mosi_reg    <= mosi_next;
         ldac_n_reg  <= ldac_n_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      div_cnt_next = div_cnt_reg;
      phase_next   = phase_reg;
      bit_cnt_next = bit_cnt_reg;
      gap_cnt_next = gap_cnt_reg;
      shift_next   = shift_reg;
      q_frame_next = q_frame_reg;
      if (!en_in) begin
         state_next   = ST_IDLE;
         div_cnt_next = '0;
         phase_next   = 1'b0;
         bit_cnt_next = '0;
         gap_cnt_next = '0;
      end else begin
         unique case (state_reg)
            ST_IDLE: begin
               if (sample_stb) begin
                  state_next   = ST_SHIFT_A;
                  shift_next   = {CMD_A, i_data12};
                  q_frame_next = {CMD_B, q_data12};
                  div_cnt_next = '0;
                  phase_next   = 1'b0;
                  bit_cnt_next = '0;
               end
            end
            ST_SHIFT_A, ST_SHIFT_B: begin
               if (div_cnt_reg == DIV_LAST) begin
                  div_cnt_next = '0;
                  if (!phase_reg) begin
                     phase_next = 1'b1;
                  end else begin
                     phase_next = 1'b0;
                     if (bit_cnt_reg == 4'd15) begin
                        state_next   = (state_reg == ST_SHIFT_A) ? ST_GAP_A : ST_GAP_B;
                        gap_cnt_next = '0;
                     end else begin
                        bit_cnt_next = bit_cnt_reg + 4'd1;
                        shift_next   = {shift_reg[14:0], 1'b0};
                     end
                  end
               end else begin
                  div_cnt_next = div_cnt_reg + DIV_W'(1);
               end
            end
            ST_GAP_A: begin
               if (gap_cnt_reg == GAP_LAST) begin
                  state_next   = ST_SHIFT_B;
                  shift_next   = q_frame_reg;
                  div_cnt_next = '0;
                  phase_next   = 1'b0;
                  bit_cnt_next = '0;
               end else begin
                  gap_cnt_next = gap_cnt_reg + GAP_W'(1);
               end
            end
            ST_GAP_B: begin
               if (gap_cnt_reg == GAP_LAST) begin
`ifdef DAC_LDAC_EN
                  state_next   = ST_LDAC;
                  div_cnt_next = '0;
`else
                  state_next   = ST_IDLE;
`endif
               end else begin
                  gap_cnt_next = gap_cnt_reg + GAP_W'(1);
               end
            end
`ifdef DAC_LDAC_EN
            ST_LDAC: begin
               if (div_cnt_reg == DIV_LAST) begin
                  state_next = ST_IDLE;
               end else begin
                  div_cnt_next = div_cnt_reg + DIV_W'(1);
               end
            end
`endif
            default: state_next = ST_IDLE;
         endcase
      end
   end

   // Outputs are registered from the next-state view so they align with the state they describe.
   always_comb begin
      busy_next   = (state_next != ST_IDLE);
      done_next   = en_in && (state_reg != ST_IDLE) && (state_next == ST_IDLE);
      sclk_next   = 1'b0;
      cs_n_next   = 1'b1;
      mosi_next   = 1'b0;
      ldac_n_next = LDAC_IDLE;
      case (state_next)
         ST_SHIFT_A, ST_SHIFT_B: begin
            cs_n_next = 1'b0;
            sclk_next = phase_next;
            mosi_next = shift_next[15];
         end
`ifdef DAC_LDAC_EN
         ST_LDAC: ldac_n_next = 1'b0;
`endif
         default: ;
      endcase
   end

   assign busy    = busy_reg;
   assign done    = done_reg;
   assign sclk    = sclk_reg;
   assign cs_n    = cs_n_reg;
   assign mosi    = mosi_reg;
   assign ldac_n  = ldac_n_reg;
   // A strobe that cannot be taken is flagged in the same cycle it arrives.
   assign overrun = sample_stb & en_in & busy_reg;

endmodule

// File: tb/tb_iq_dac_spi_tx.sv
// Directed bench for iq_dac_spi_tx: default-parameter DUT plus a fast 12-bit DUT,
// each observed by an SPI frame decoder.
module tb_iq_dac_spi_tx;

`ifdef DAC_LDAC_EN
   localparam int   D_MAIN = 135;
   localparam int   D_FAST = 68;
   localparam int   LD     = 1;
   localparam logic LDAC_I = 1'b1;
`else
   localparam int   D_MAIN = 133;
   localparam int   D_FAST = 67;
   localparam int   LD     = 0;
   localparam logic LDAC_I = 1'b0;
`endif

   logic clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   logic        rst_in, en_in, sample_stb, f_stb;
   logic [9:0]  i_in, q_in;
   logic [11:0] f_i, f_q;
   logic busy, done, overrun, sclk, cs_n, mosi, ldac_n;
   logic f_busy, f_done, f_overrun, f_sclk, f_cs_n, f_mosi, f_ldac_n;

   iq_dac_spi_tx dut (
      .clk_in(clk_in), .rst_in(rst_in), .en_in(en_in), .sample_stb(sample_stb),
      .I_in(i_in), .Q_in(q_in), .busy(busy), .done(done), .overrun(overrun),
      .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .ldac_n(ldac_n)
   );

   iq_dac_spi_tx #(.BIT_WIDTH(12), .CLK_DIV(1), .CS_GAP(1)) dut_fast (
      .clk_in(clk_in), .rst_in(rst_in), .en_in(en_in), .sample_stb(f_stb),
      .I_in(f_i), .Q_in(f_q), .busy(f_busy), .done(f_done), .overrun(f_overrun),
      .sclk(f_sclk), .cs_n(f_cs_n), .mosi(f_mosi), .ldac_n(f_ldac_n)
   );

   int cyc = 0;
   always @(posedge clk_in) cyc <= cyc + 1;

   // Main-DUT SPI decoder
   logic        m_sclk_d = 1'b0, m_cs_d = 1'b1, m_mosi_d = 1'b0, m_ld_d = 1'b1;
   logic [15:0] m_sr = '0;
   int          m_bits = 0, m_last_rise = 0, m_per_bad = 0, m_glitch = 0, m_ldac_falls = 0;
   logic [15:0] m_frames[$];
   int          m_nbits[$];

   always @(negedge clk_in) begin
      if (sclk && !m_sclk_d) begin
         m_sr   <= {m_sr[14:0], mosi};
         m_bits <= m_bits + 1;
         if (m_bits > 0 && (cyc - m_last_rise) != 4) m_per_bad <= m_per_bad + 1;
         m_last_rise <= cyc;
      end
      if ((sclk && m_sclk_d && mosi != m_mosi_d) || (sclk && cs_n)) m_glitch <= m_glitch + 1;
      if (!cs_n && m_cs_d) m_bits <= 0;
      if (cs_n && !m_cs_d) begin
         m_frames.push_back(m_sr);
         m_nbits.push_back(m_bits);
      end
      if (!ldac_n && m_ld_d) m_ldac_falls <= m_ldac_falls + 1;
      m_sclk_d <= sclk;
      m_cs_d   <= cs_n;
      m_mosi_d <= mosi;
      m_ld_d   <= ldac_n;
   end

   // Fast-DUT SPI decoder
   logic        f_sclk_d = 1'b0, f_cs_d = 1'b1;
   logic [15:0] f_sr = '0;
   int          f_bits = 0, f_last_rise = 0, f_per_bad = 0;
   logic [15:0] f_frames[$];
   int          f_nbits[$];

   always @(negedge clk_in) begin
      if (f_sclk && !f_sclk_d) begin
         f_sr   <= {f_sr[14:0], f_mosi};
         f_bits <= f_bits + 1;
         if (f_bits > 0 && (cyc - f_last_rise) != 2) f_per_bad <= f_per_bad + 1;
         f_last_rise <= cyc;
      end
      if (!f_cs_n && f_cs_d) f_bits <= 0;
      if (f_cs_n && !f_cs_d) begin
         f_frames.push_back(f_sr);
         f_nbits.push_back(f_bits);
      end
      f_sclk_d <= f_sclk;
      f_cs_d   <= f_cs_n;
   end

   int total = 0;
   int bad   = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   function automatic logic [31:0] m_frame(int idx);
      if (idx < m_frames.size()) return {16'h0, m_frames[idx]};
      return 32'hFFFF_FFFF;
   endfunction
   function automatic logic [31:0] m_nb(int idx);
      if (idx < m_nbits.size()) return 32'(m_nbits[idx]);
      return 32'hFFFF_FFFF;
   endfunction
   function automatic logic [31:0] f_frame(int idx);
      if (idx < f_frames.size()) return {16'h0, f_frames[idx]};
      return 32'hFFFF_FFFF;
   endfunction

   task automatic wait_done(input bit fast, output int at);
      at = -1;
      for (int k = 0; k < 400; k++) begin
         tick();
         if ((fast ? f_done : done) === 1'b1) begin
            at = cyc;
            return;
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int t0, td, base, ld0, ov, d1, d2, nd;
      rst_in = 1'b0; en_in = 1'b0; sample_stb = 1'b0; f_stb = 1'b0;
      i_in = '0; q_in = '0; f_i = '0; f_q = '0;
      repeat (3) tick();
      check_val("rst_cs_n", cs_n, 1'b1);
      check_val("rst_sclk", sclk, 1'b0);
      check_val("rst_busy", busy, 1'b0);
      check_val("rst_done", done, 1'b0);
      check_val("rst_overrun", overrun, 1'b0);
      check_val("rst_mosi", mosi, 1'b0);
      check_val("rst_ldac_n", ldac_n, LDAC_I);
      check_val("rst_f_cs_n", f_cs_n, 1'b1);
      rst_in = 1'b1;
      repeat (2) tick();
      check_val("idle_cs_n", cs_n, 1'b1);
      check_val("idle_busy", busy, 1'b0);
      check_val("idle_ldac_n", ldac_n, LDAC_I);
      en_in = 1'b1;
      tick();

      // single pair, inputs changed after capture
      base = m_frames.size(); ld0 = m_ldac_falls;
      i_in = 10'h200; q_in = 10'h3FF; sample_stb = 1'b1; t0 = cyc;
      tick();
      sample_stb = 1'b0; i_in = '0; q_in = '0;
      check_val("start_cs_n", cs_n, 1'b0);
      check_val("start_busy", busy, 1'b1);
      check_val("start_mosi", mosi, 1'b0);
      check_val("start_sclk", sclk, 1'b0);
      wait_done(1'b0, td);
      check_val("pair_latency", td - t0, D_MAIN);
      check_val("pair_busy_at_done", busy, 1'b0);
      tick();
      check_val("pair_done_pulse", done, 1'b0);
      check_val("pair_frame_a", m_frame(base), 32'h3800);
      check_val("pair_frame_b", m_frame(base + 1), 32'hBFFC);
      check_val("pair_bits_a", m_nb(base), 16);
      check_val("pair_bits_b", m_nb(base + 1), 16);
      check_val("pair_ldac", m_ldac_falls - ld0, LD);

      // strobe while busy
      base = m_frames.size();
      i_in = 10'h200; q_in = 10'h3FF; sample_stb = 1'b1; t0 = cyc;
      tick();
      sample_stb = 1'b0; i_in = 10'h155; q_in = 10'h0AA;
      repeat (9) tick();
      sample_stb = 1'b1;
      #1;
      check_val("ovr_pulse", overrun, 1'b1);
      check_val("ovr_cycle", cyc - t0, 10);
      tick();
      sample_stb = 1'b0;
      #1;
      check_val("ovr_clear", overrun, 1'b0);
      wait_done(1'b0, td);
      check_val("ovr_latency", td - t0, D_MAIN);
      check_val("ovr_frame_a", m_frame(base), 32'h3800);
      check_val("ovr_frame_b", m_frame(base + 1), 32'hBFFC);
      tick();

      // strobe held high: back-to-back pairs
      base = m_frames.size(); ld0 = m_ldac_falls;
      i_in = 10'h200; q_in = 10'h3FF; sample_stb = 1'b1; t0 = cyc;
      ov = 0; d1 = -1; d2 = -1;
      for (int k = 0; k <= 2 * D_MAIN; k++) begin
         #1;
         if (overrun) ov++;
         if (done) begin
            if (d1 < 0) d1 = cyc;
            else d2 = cyc;
         end
         tick();
      end
      sample_stb = 1'b0;
      check_val("b2b_done1", d1 - t0, D_MAIN);
      check_val("b2b_done2", d2 - t0, 2 * D_MAIN);
      check_val("b2b_overruns", ov, 2 * (D_MAIN - 1));
      wait_done(1'b0, td);
      check_val("b2b_done3", td - t0, 3 * D_MAIN);
      check_val("b2b_nframes", m_frames.size() - base, 6);
      for (int k = 0; k < 3; k++) begin
         check_val("b2b_frame_a", m_frame(base + 2 * k), 32'h3800);
         check_val("b2b_frame_b", m_frame(base + 2 * k + 1), 32'hBFFC);
      end
      check_val("b2b_ldac", m_ldac_falls - ld0, 3 * LD);
      tick();

      // en_in dropped during bit 7 of frame B
      base = m_frames.size(); ld0 = m_ldac_falls;
      i_in = 10'h200; q_in = 10'h3FF; sample_stb = 1'b1; t0 = cyc;
      tick();
      sample_stb = 1'b0;
      while (cyc < t0 + 96) tick();
      en_in = 1'b0;
      tick();
      check_val("abort_cs_n", cs_n, 1'b1);
      check_val("abort_sclk", sclk, 1'b0);
      check_val("abort_mosi", mosi, 1'b0);
      check_val("abort_busy", busy, 1'b0);
      check_val("abort_ldac_n", ldac_n, LDAC_I);
      nd = 0;
      repeat (60) begin
         if (done) nd++;
         tick();
      end
      check_val("abort_no_done", nd, 0);
      check_val("abort_no_ldac", m_ldac_falls - ld0, 0);
      check_val("abort_frame_a", m_frame(base), 32'h3800);
      check_val("abort_bits_b", m_nb(base + 1), 7);
      en_in = 1'b1;
      tick();
      base = m_frames.size();
      i_in = 10'h155; q_in = 10'h0AA; sample_stb = 1'b1; t0 = cyc;
      tick();
      sample_stb = 1'b0;
      wait_done(1'b0, td);
      check_val("post_abort_latency", td - t0, D_MAIN);
      check_val("post_abort_frame_a", m_frame(base), 32'h3554);
      check_val("post_abort_frame_b", m_frame(base + 1), 32'hB2A8);
      tick();

      // asynchronous reset mid-transfer
      i_in = 10'h200; q_in = 10'h3FF; sample_stb = 1'b1;
      tick();
      sample_stb = 1'b0;
      repeat (20) tick();
      check_val("pre_rst_cs_n", cs_n, 1'b0);
      #2 rst_in = 1'b0;
      #1;
      check_val("async_rst_cs_n", cs_n, 1'b1);
      check_val("async_rst_busy", busy, 1'b0);
      check_val("async_rst_sclk", sclk, 1'b0);
      check_val("async_rst_mosi", mosi, 1'b0);
      check_val("async_rst_ldac_n", ldac_n, LDAC_I);
      tick();
      rst_in = 1'b1;
      repeat (2) tick();

      // fast configuration: 12-bit, CLK_DIV=1, CS_GAP=1
      base = f_frames.size();
      f_i = 12'hABC; f_q = 12'h123; f_stb = 1'b1; t0 = cyc;
      tick();
      f_stb = 1'b0;
      wait_done(1'b1, td);
      check_val("fast_latency", td - t0, D_FAST);
      check_val("fast_frame_a", f_frame(base), 32'h3ABC);
      check_val("fast_frame_b", f_frame(base + 1), 32'hB123);
      check_val("fast_bits_a", (base < f_nbits.size()) ? f_nbits[base] : -1, 16);
      check_val("fast_sclk_period", f_per_bad, 0);

      check_val("main_sclk_period", m_per_bad, 0);
      check_val("main_mosi_stable", m_glitch, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
